// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin sharing of a single uart_tx serializer among NUM_REQ byte producers.
// Each accepted byte is latched, launched with a one-cycle Tx_DV, tracked until Tx_Done
// (or a watchdog abort), and followed by GAP_CYCLES idle cycles before the next launch.
// Optional feature macro: UART_TX_ARB_LOCK_EN keeps ownership on one requester until it
// sends a byte flagged with i_Req_Last (packet locking).
//
//  state     | meaning
//  IDLE      | no transfer; arbitrate when a request is valid and the serializer is free
//  LAUNCH    | byte latched, grant set; Tx_DV and Req_Ready are issued from here
//  WAIT_DONE | serializer shifting; wait for Tx_Done or watchdog expiry
//  GAP       | inter-byte idle time, grant still held
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                   i_Clock,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     i_Req_Valid,
    input  logic [8*NUM_REQ-1:0]   i_Req_Data,
    input  logic [NUM_REQ-1:0]     i_Req_Last,
    output logic [NUM_REQ-1:0]     o_Req_Ready,
    output logic [NUM_REQ-1:0]     o_Req_Done,
    output logic [NUM_REQ-1:0]     o_Grant,
    output logic                   o_Tx_DV,
    output logic [7:0]             o_Tx_Byte,
    input  logic                   i_Tx_Active,
    input  logic                   i_Tx_Done,
    output logic                   o_Busy,
    output logic                   o_Error
);

    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int WD_LOAD = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam int WD_W    = $clog2(WD_LOAD + 2);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [GAP_W-1:0]   gap_cnt;
    logic [WD_W-1:0]    wd_cnt;
    logic               lock;

    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   cand;
    logic [7:0]         sel_byte;

`ifdef UART_TX_ARB_LOCK_EN
    logic [IDX_W-1:0]   lock_idx;
    logic               sel_last;
`else
    // Last flags have no meaning without packet locking; the port is kept for compatibility.
    logic               unused_last;
    assign unused_last = ^i_Req_Last;
`endif

    // Round-robin pick: first valid requester after ptr; lowest offset wins because it is visited last.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_byte  = '0;
        cand      = '0;
`ifdef UART_TX_ARB_LOCK_EN
        sel_last  = 1'b0;
`endif
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (i_Req_Valid[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
                sel_byte  = i_Req_Data[{cand, 3'b000} +: 8];
`ifdef UART_TX_ARB_LOCK_EN
                sel_last  = i_Req_Last[cand];
`endif
            end
        end
`ifdef UART_TX_ARB_LOCK_EN
        // A locked owner is the only candidate, even while it has nothing pending.
        if (lock) begin
            sel_found = i_Req_Valid[lock_idx];
            sel_idx   = lock_idx;
            sel_byte  = i_Req_Data[{lock_idx, 3'b000} +: 8];
            sel_last  = i_Req_Last[lock_idx];
        end
`endif
    end

    // Sequencer: single registered FSM, every output is a flop.
    always_ff @(posedge i_Clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            ptr         <= IDX_W'(NUM_REQ - 1);
            gap_cnt     <= '0;
            wd_cnt      <= '0;
            lock        <= 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
            lock_idx    <= '0;
`endif
            o_Req_Ready <= '0;
            o_Req_Done  <= '0;
            o_Grant     <= '0;
            o_Tx_DV     <= 1'b0;
            o_Tx_Byte   <= '0;
            o_Busy      <= 1'b0;
            o_Error     <= 1'b0;
        end else begin
            o_Req_Ready <= '0;
            o_Req_Done  <= '0;
            o_Tx_DV     <= 1'b0;
            o_Error     <= 1'b0;
            unique case (state)
                IDLE: begin
                    // Never launch over a serializer that is still shifting.
                    if (sel_found && !i_Tx_Active) begin
                        o_Tx_Byte <= sel_byte;
                        o_Grant   <= ONE_HOT0 << sel_idx;
                        o_Busy    <= 1'b1;
                        state     <= LAUNCH;
`ifdef UART_TX_ARB_LOCK_EN
                        // Pointer moves only when a packet ends, so the next packet goes to someone else.
                        if (sel_last) begin
                            lock <= 1'b0;
                            ptr  <= sel_idx;
                        end else begin
                            lock     <= 1'b1;
                            lock_idx <= sel_idx;
                        end
`else
                        ptr <= sel_idx;
`endif
                    end
                end
                LAUNCH: begin
                    o_Tx_DV     <= 1'b1;
                    o_Req_Ready <= o_Grant;
                    wd_cnt      <= WD_W'(WD_LOAD);
                    state       <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    // Done is checked first so a completion on the expiry cycle is not an error.
                    if (i_Tx_Done) begin
                        o_Req_Done <= o_Grant;
                        gap_cnt    <= GAP_W'(GAP_CYCLES - 1);
                        state      <= GAP;
                    end else if ((TIMEOUT_CYCLES > 0) && (wd_cnt == '0)) begin
                        o_Error <= 1'b1;
                        lock    <= 1'b0;
                        gap_cnt <= GAP_W'(GAP_CYCLES - 1);
                        state   <= GAP;
                    end else if (wd_cnt != '0) begin
                        wd_cnt <= wd_cnt - WD_W'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state  <= IDLE;
                        o_Busy <= 1'b0;
                        if (!lock) begin
                            o_Grant <= '0;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural uart_tx stand-in, queue-based requesters,
// a table of arbitration scenarios plus directed latency, busy-guard, watchdog and reset sequences.
module tb_uart_tx_arbiter;

    localparam int NREQ   = 4;
    localparam int TX_LEN = 20;

    logic        clk;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [3:0]  req_done;
    logic [3:0]  grant;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic        tx_active;
    logic        tx_active_stub;
    logic        force_active;
    logic        tx_done;
    logic        busy;
    logic        error;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int ready_cnt = 0;
    int done_cnt  = 0;
    int err_cnt   = 0;
    int stub_cnt  = 0;
    bit stub_hang = 0;

    logic [10:0] pend[$];   // {req[1:0], last, data[7:0]} in issue order
    logic [7:0]  sent[$];

    typedef struct packed {
        logic [3:0]        n;
        logic [0:5][10:0]  items;
        logic [0:5][7:0]   exp;
    } vec_t;

    vec_t vecs [7];

    assign tx_active = tx_active_stub | force_active;

    uart_tx_arbiter #(
        .NUM_REQ(NREQ),
        .GAP_CYCLES(2),
        .TIMEOUT_CYCLES(1000)
    ) dut (
        .i_Clock(clk),
        .reset_n(reset_n),
        .i_Req_Valid(req_valid),
        .i_Req_Data(req_data),
        .i_Req_Last(req_last),
        .o_Req_Ready(req_ready),
        .o_Req_Done(req_done),
        .o_Grant(grant),
        .o_Tx_DV(tx_dv),
        .o_Tx_Byte(tx_byte),
        .i_Tx_Active(tx_active),
        .i_Tx_Done(tx_done),
        .o_Busy(busy),
        .o_Error(error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] mk(input int r, input bit l, input logic [7:0] d);
        return {r[1:0], l, d};
    endfunction

    // Requesters: head item per requester is driven; popped when its Ready pulse is seen.
    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < NREQ; k++) begin
                if (req_ready[k]) begin
                    for (int i = 0; i < pend.size(); i++) begin
                        if (int'(pend[i][10:9]) == k) begin
                            pend.delete(i);
                            break;
                        end
                    end
                end
            end
            for (int k = 0; k < NREQ; k++) begin
                req_valid[k]       = 1'b0;
                req_last[k]        = 1'b0;
                req_data[8*k +: 8] = 8'h00;
                for (int i = 0; i < pend.size(); i++) begin
                    if (int'(pend[i][10:9]) == k) begin
                        req_valid[k]       = 1'b1;
                        req_last[k]        = pend[i][8];
                        req_data[8*k +: 8] = pend[i][7:0];
                        break;
                    end
                end
            end
        end
    end

    // Serializer stand-in: Active for TX_LEN cycles after Tx_DV, then a Done pulse unless hung.
    initial begin
        tx_active_stub = 1'b0;
        tx_done        = 1'b0;
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            if (!reset_n) begin
                stub_cnt       = 0;
                tx_active_stub = 1'b0;
            end else if (stub_cnt > 0) begin
                stub_cnt--;
                if (stub_cnt == 0) begin
                    tx_active_stub = 1'b0;
                    tx_done        = !stub_hang;
                end
            end else if (tx_dv) begin
                stub_cnt       = TX_LEN;
                tx_active_stub = 1'b1;
            end
        end
    end

    // Monitor: records launched bytes and pulse counts; Ready must name the granted requester.
    initial begin
        forever begin
            @(negedge clk);
            ready_cnt += $countones(req_ready);
            done_cnt  += $countones(req_done);
            err_cnt   += int'(error);
            if (tx_dv) begin
                sent.push_back(tx_byte);
                chk("ready_matches_grant", {28'd0, req_ready}, {28'd0, grant});
            end
        end
    end

    task automatic wait_idle(input int budget, input string name);
        int c;
        c = 0;
        do begin
            @(posedge clk);
            #1;
            c++;
        end while ((pend.size() != 0 || busy) && c < budget);
        chk({name, "_idle"}, {31'd0, (pend.size() != 0) || busy}, 32'd0);
    endtask

    initial begin
        int r0, d0, e0;
        int t_dv, t_err;
        logic [7:0] got;

        vecs[0] = '{4'd4, {mk(0,1,8'h41), mk(0,1,8'h42), mk(2,1,8'h43), mk(3,1,8'h44), 11'd0, 11'd0},
                          {8'h41, 8'h43, 8'h44, 8'h42, 8'h00, 8'h00}};
        vecs[1] = '{4'd1, {mk(1,1,8'h61), 11'd0, 11'd0, 11'd0, 11'd0, 11'd0},
                          {8'h61, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[2] = '{4'd4, {mk(0,1,8'h10), mk(1,1,8'h11), mk(2,1,8'h12), mk(3,1,8'h13), 11'd0, 11'd0},
                          {8'h12, 8'h13, 8'h10, 8'h11, 8'h00, 8'h00}};
        vecs[3] = '{4'd2, {mk(0,1,8'h20), mk(3,1,8'h23), 11'd0, 11'd0, 11'd0, 11'd0},
                          {8'h23, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[4] = '{4'd2, {mk(0,1,8'h30), mk(1,1,8'h31), 11'd0, 11'd0, 11'd0, 11'd0},
                          {8'h31, 8'h30, 8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[5] = '{4'd1, {mk(0,1,8'h55), 11'd0, 11'd0, 11'd0, 11'd0, 11'd0},
                          {8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
`ifdef UART_TX_ARB_LOCK_EN
        vecs[6] = '{4'd4, {mk(1,0,8'hA0), mk(1,0,8'hA1), mk(1,1,8'hA2), mk(0,1,8'hB0), 11'd0, 11'd0},
                          {8'hA0, 8'hA1, 8'hA2, 8'hB0, 8'h00, 8'h00}};
`else
        vecs[6] = '{4'd4, {mk(1,0,8'hA0), mk(1,0,8'hA1), mk(1,1,8'hA2), mk(0,1,8'hB0), 11'd0, 11'd0},
                          {8'hA0, 8'hB0, 8'hA1, 8'hA2, 8'h00, 8'h00}};
`endif

        force_active = 1'b0;
        reset_n      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {7'd0, req_ready, req_done, grant, tx_dv, tx_byte, busy, error}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Arbitration scenarios
        for (int v = 0; v < 7; v++) begin
            @(posedge clk);
            #1;
            sent.delete();
            r0 = ready_cnt;
            d0 = done_cnt;
            e0 = err_cnt;
            for (int i = 0; i < int'(vecs[v].n); i++) pend.push_back(vecs[v].items[i]);
            wait_idle(300 * int'(vecs[v].n), $sformatf("vec%0d", v));
            chk($sformatf("vec%0d_count", v), sent.size(), {28'd0, vecs[v].n});
            for (int i = 0; i < int'(vecs[v].n); i++) begin
                got = (i < sent.size()) ? sent[i] : 8'hxx;
                chk($sformatf("vec%0d_byte%0d", v, i), {24'd0, got}, {24'd0, vecs[v].exp[i]});
            end
            chk($sformatf("vec%0d_ready_pulses", v), ready_cnt - r0, {28'd0, vecs[v].n});
            chk($sformatf("vec%0d_done_pulses", v), done_cnt - d0, {28'd0, vecs[v].n});
            chk($sformatf("vec%0d_no_error", v), err_cnt - e0, 32'd0);
        end

        // Latency and gap timing for a lone request
        @(posedge clk);
        #1;
        pend.push_back(mk(1, 1, 8'h61));
        @(posedge clk);
        #1;
        chk("lat_grant", {28'd0, grant}, 32'h2);
        chk("lat_byte", {24'd0, tx_byte}, 32'h61);
        chk("lat_dv_not_yet", {31'd0, tx_dv}, 32'd0);
        chk("lat_busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        chk("lat_dv", {31'd0, tx_dv}, 32'd1);
        chk("lat_ready", {28'd0, req_ready}, 32'h2);
        @(posedge clk);
        #1;
        chk("lat_dv_pulse", {31'd0, tx_dv}, 32'd0);
        for (int c = 0; c < 100; c++) begin
            if (req_done != 4'd0) break;
            @(posedge clk);
            #1;
        end
        chk("single_done", {28'd0, req_done}, 32'h2);
        chk("gap_grant0", {28'd0, grant}, 32'h2);
        @(posedge clk);
        #1;
        chk("gap_grant1", {28'd0, grant}, 32'h2);
        chk("done_pulse", {28'd0, req_done}, 32'd0);
        @(posedge clk);
        #1;
        chk("idle_grant", {28'd0, grant}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Busy guard
        sent.delete();
        force_active = 1'b1;
        pend.push_back(mk(2, 1, 8'h7E));
        t_dv = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (tx_dv || grant != 4'd0) t_dv = 1;
        end
        chk("busy_guard_held", t_dv, 32'd0);
        force_active = 1'b0;
        wait_idle(200, "busy_guard");
        chk("busy_guard_sent", {24'd0, (sent.size() == 1) ? sent[0] : 8'hxx}, 32'h7E);

        // Watchdog abort, then normal service
        sent.delete();
        d0 = done_cnt;
        e0 = err_cnt;
        stub_hang = 1'b1;
        pend.push_back(mk(3, 1, 8'h77));
        t_dv  = -1;
        t_err = -1;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            if (tx_dv) begin
                t_dv = cyc;
                break;
            end
        end
        for (int c = 0; c < 1100; c++) begin
            @(posedge clk);
            #1;
            if (error) begin
                t_err = cyc;
                break;
            end
        end
        chk("wd_latency", t_err - t_dv, 32'd1000);
        @(posedge clk);
        #1;
        chk("wd_error_pulse", {31'd0, error}, 32'd0);
        stub_hang = 1'b0;
        wait_idle(100, "wd_abort");
        chk("wd_no_done", done_cnt - d0, 32'd0);
        chk("wd_one_error", err_cnt - e0, 32'd1);
        pend.push_back(mk(0, 1, 8'h78));
        wait_idle(200, "wd_after");
        chk("wd_next_byte", {24'd0, (sent.size() == 2) ? sent[1] : 8'hxx}, 32'h78);
        chk("wd_next_done", done_cnt - d0, 32'd1);

        // Reset in WAIT_DONE
        pend.push_back(mk(1, 1, 8'h5A));
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            if (tx_dv) break;
        end
        repeat (3) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("midreset_outputs", {7'd0, req_ready, req_done, grant, tx_dv, tx_byte, busy, error}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_idle", {27'd0, busy, grant}, 32'd0);
        sent.delete();
        pend.push_back(mk(2, 1, 8'h99));
        wait_idle(200, "post_reset");
        chk("post_reset_byte", {24'd0, (sent.size() == 1) ? sent[0] : 8'hxx}, 32'h99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL global_timeout actual=%0d cycles required=completion", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "time limit");
    end

endmodule
